// File: rtl/imem_arb.sv
// imem_arb: two-port (fetch/loader) arbiter for a single-port 32-bit instruction memory.
// Loader has priority; fetch is guaranteed a slot after MAX_STREAK consecutive loader wins.
module imem_arb #(
    parameter int MAX_STREAK = 4,
    parameter int AW = 11
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_boot,
    input  logic          i_f_req,
    input  logic [31:0]   i_f_addr,
    output logic          o_f_gnt,
    output logic          o_f_rvalid,
    output logic [31:0]   o_f_rdata,
    input  logic          i_l_req,
    input  logic          i_l_we,
    input  logic [31:0]   i_l_addr,
    input  logic [31:0]   i_l_wdata,
    output logic          o_l_gnt,
    output logic          o_l_rvalid,
    output logic [31:0]   o_l_rdata,
    output logic          o_l_err,
    output logic          o_m_en,
    output logic          o_m_we,
    output logic [AW-1:0] o_m_addr,
    output logic [31:0]   o_m_wdata,
    input  logic [31:0]   i_m_rdata
);
    localparam int SW = $clog2(MAX_STREAK + 1);

    logic [SW-1:0] streak;
    logic          rd_pend, tag, err_q;
    logic [31:0]   f_hold, l_hold;
    logic [31:0]   l_hi;
    logic          l_oor, f_gnt, l_gnt, l_go;
    logic          unused_bits;

    assign l_hi = i_l_addr >> (AW + 2);
    assign unused_bits = ^{i_f_addr[31:AW+2], i_f_addr[1:0], i_l_addr[1:0]};

    always_comb begin
        l_oor = |l_hi;
        f_gnt = i_rst & ~i_boot & i_f_req & (~i_l_req | (streak == SW'(MAX_STREAK)));
        l_gnt = i_rst & i_l_req & ~f_gnt;
        // out-of-range loader accesses are accepted but never reach memory
        l_go = l_gnt & ~l_oor;
        o_m_en = f_gnt | l_go;
        o_m_we = l_go & i_l_we;
        o_m_addr = f_gnt ? i_f_addr[AW+1:2] : i_l_addr[AW+1:2];
    end

    assign o_m_wdata  = i_l_wdata;
    assign o_f_gnt    = f_gnt;
    assign o_l_gnt    = l_gnt;
    assign o_f_rvalid = rd_pend & ~tag;
    assign o_l_rvalid = rd_pend & tag;
    assign o_f_rdata  = o_f_rvalid ? i_m_rdata : f_hold;
    assign o_l_rdata  = o_l_rvalid ? i_m_rdata : l_hold;
    assign o_l_err    = err_q;

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            streak  <= '0;
            rd_pend <= 1'b0;
            tag     <= 1'b0;
            err_q   <= 1'b0;
            f_hold  <= '0;
            l_hold  <= '0;
        end else begin
            rd_pend <= f_gnt | (l_go & ~i_l_we);
            tag     <= l_gnt;
            err_q   <= l_gnt & l_oor;
            if (o_f_rvalid) f_hold <= i_m_rdata;
            if (o_l_rvalid) l_hold <= i_m_rdata;
            // the streak only counts loader wins that actually delayed a waiting fetch
            streak  <= (i_boot | f_gnt | ~i_f_req) ? '0 :
                       (l_gnt && streak != SW'(MAX_STREAK)) ? streak + 1'b1 : streak;
        end
    end
endmodule

// File: tb/tb_imem_arb.sv
// tb_imem_arb: directed vector table, hand sequences and random traffic
// checked against a cycle-level reference model of the arbitration rules.
module tb_imem_arb;
    localparam int MAX = 4;
    localparam int AW = 11;

    logic          clk = 1'b0;
    logic          rst, boot, f_req, l_req, l_we;
    logic [31:0]   f_addr, l_addr, l_wdata, m_rdata;
    logic          f_gnt, f_rvalid, l_gnt, l_rvalid, l_err, m_en, m_we;
    logic [31:0]   f_rdata, l_rdata, m_wdata;
    logic [AW-1:0] m_addr;

    int checks = 0;
    int errors = 0;

    imem_arb #(.MAX_STREAK(MAX), .AW(AW)) dut (
        .i_clk(clk), .i_rst(rst), .i_boot(boot),
        .i_f_req(f_req), .i_f_addr(f_addr), .o_f_gnt(f_gnt),
        .o_f_rvalid(f_rvalid), .o_f_rdata(f_rdata),
        .i_l_req(l_req), .i_l_we(l_we), .i_l_addr(l_addr), .i_l_wdata(l_wdata),
        .o_l_gnt(l_gnt), .o_l_rvalid(l_rvalid), .o_l_rdata(l_rdata), .o_l_err(l_err),
        .o_m_en(m_en), .o_m_we(m_we), .o_m_addr(m_addr), .o_m_wdata(m_wdata),
        .i_m_rdata(m_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, boot, freq;
        logic [31:0] faddr;
        logic        lreq, lwe;
        logic [31:0] laddr, lwdata, mrd;
        logic        fg, lg, men, mwe;
        logic [10:0] maddr;
        logic        fv, lv, err;
        logic [31:0] frd, lrd;
    } vec_t;

    vec_t vec [11];

    // reference model state: streak length, pending read owner, pending error, last delivered data
    int          s;
    bit          pf, pl, pe, e_fg, e_lg, e_oor;
    logic [31:0] fl, ll;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
        end
    endtask

    task automatic model_check();
        bit men;
        logic [31:0] ea;
        e_oor = (l_addr >> (AW + 2)) != 0;
        e_fg  = rst && !boot && f_req && (!l_req || s >= MAX);
        e_lg  = rst && l_req && !e_fg;
        men   = e_fg || (e_lg && !e_oor);
        chk("m_f_gnt", f_gnt, e_fg);
        chk("m_l_gnt", l_gnt, e_lg);
        chk("m_en", m_en, men);
        chk("m_we", m_we, e_lg && !e_oor && l_we);
        if (men) begin
            ea = ((e_fg ? f_addr : l_addr) / 4) % (1 << AW);
            chk("m_addr", {21'b0, m_addr}, ea);
        end
        if (e_lg && !e_oor && l_we) chk("m_wdata", m_wdata, l_wdata);
        chk("m_f_rvalid", f_rvalid, pf);
        chk("m_l_rvalid", l_rvalid, pl);
        chk("m_f_rdata", f_rdata, pf ? m_rdata : fl);
        chk("m_l_rdata", l_rdata, pl ? m_rdata : ll);
        chk("m_l_err", l_err, pe);
    endtask

    task automatic model_update();
        if (!rst) begin
            s = 0; pf = 0; pl = 0; pe = 0; fl = '0; ll = '0;
        end else begin
            if (pf) fl = m_rdata;
            if (pl) ll = m_rdata;
            pf = e_fg;
            pl = e_lg && !e_oor && !l_we;
            pe = e_lg && e_oor;
            if (boot || e_fg || !f_req) s = 0;
            else if (e_lg) s = (s + 1 > MAX) ? MAX : s + 1;
        end
    endtask

    task automatic adv();
        model_check();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic drive(input logic r, input logic b, input logic fr, input logic [31:0] fa,
                         input logic lr, input logic lw, input logic [31:0] la,
                         input logic [31:0] wd, input logic [31:0] md);
        rst = r; boot = b; f_req = fr; f_addr = fa;
        l_req = lr; l_we = lw; l_addr = la; l_wdata = wd; m_rdata = md;
        #1;
    endtask

    initial begin
        vec[0]  = '{'0,'0,'1,32'h10,'1,'0,'0,'0,'0,                       '0,'0,'0,'0,11'h0,  '0,'0,'0,'0,'0};
        vec[1]  = '{'1,'0,'1,32'h10,'0,'0,'0,'0,'0,                       '1,'0,'1,'0,11'h004,'0,'0,'0,'0,'0};
        vec[2]  = '{'1,'0,'0,'0,'0,'0,'0,'0,32'h12345678,                 '0,'0,'0,'0,11'h0,  '1,'0,'0,32'h12345678,'0};
        vec[3]  = '{'1,'0,'0,'0,'1,'1,32'h1FFC,32'hDEADBEEF,32'hAAAA0000, '0,'1,'1,'1,11'h7FF,'0,'0,'0,32'h12345678,'0};
        vec[4]  = '{'1,'0,'0,'0,'0,'0,'0,'0,32'h5555,                     '0,'0,'0,'0,11'h0,  '0,'0,'0,32'h12345678,'0};
        vec[5]  = '{'1,'0,'0,'0,'1,'0,32'h2000,'0,32'h6666,               '0,'1,'0,'0,11'h0,  '0,'0,'0,32'h12345678,'0};
        vec[6]  = '{'1,'0,'0,'0,'0,'0,'0,'0,32'h77,                       '0,'0,'0,'0,11'h0,  '0,'0,'1,32'h12345678,'0};
        vec[7]  = '{'1,'0,'0,'0,'1,'0,32'h8,'0,32'h88,                    '0,'1,'1,'0,11'h002,'0,'0,'0,32'h12345678,'0};
        vec[8]  = '{'1,'0,'1,32'hFFFFFFF0,'0,'0,'0,'0,32'hCAFEF00D,       '1,'0,'1,'0,11'h7FC,'0,'1,'0,32'h12345678,32'hCAFEF00D};
        vec[9]  = '{'1,'0,'0,'0,'0,'0,'0,'0,32'hBEEF0001,                 '0,'0,'0,'0,11'h0,  '1,'0,'0,32'hBEEF0001,32'hCAFEF00D};
        vec[10] = '{'1,'0,'0,'0,'0,'0,'0,'0,32'h1,                        '0,'0,'0,'0,11'h0,  '0,'0,'0,32'hBEEF0001,32'hCAFEF00D};

        drive(0, 0, 0, '0, 0, 0, '0, '0, '0);
        @(negedge clk);
        @(negedge clk);
        s = 0; pf = 0; pl = 0; pe = 0; fl = '0; ll = '0;

        for (int i = 0; i < 11; i++) begin
            drive(vec[i].rst, vec[i].boot, vec[i].freq, vec[i].faddr, vec[i].lreq,
                  vec[i].lwe, vec[i].laddr, vec[i].lwdata, vec[i].mrd);
            chk($sformatf("v%0d_f_gnt", i), f_gnt, vec[i].fg);
            chk($sformatf("v%0d_l_gnt", i), l_gnt, vec[i].lg);
            chk($sformatf("v%0d_m_en", i), m_en, vec[i].men);
            chk($sformatf("v%0d_m_we", i), m_we, vec[i].mwe);
            if (vec[i].men) chk($sformatf("v%0d_m_addr", i), {21'b0, m_addr}, {21'b0, vec[i].maddr});
            if (vec[i].mwe) chk($sformatf("v%0d_m_wdata", i), m_wdata, vec[i].lwdata);
            chk($sformatf("v%0d_f_rvalid", i), f_rvalid, vec[i].fv);
            chk($sformatf("v%0d_l_rvalid", i), l_rvalid, vec[i].lv);
            chk($sformatf("v%0d_l_err", i), l_err, vec[i].err);
            chk($sformatf("v%0d_f_rdata", i), f_rdata, vec[i].frd);
            chk($sformatf("v%0d_l_rdata", i), l_rdata, vec[i].lrd);
            adv();
        end

        // read granted, then reset on the following edge
        drive(1, 0, 1, 32'h20, 0, 0, '0, '0, 32'h31);
        chk("rst_mid_grant", f_gnt, 1'b1);
        adv();
        drive(0, 0, 1, 32'h20, 1, 0, 32'h4, '0, 32'h32);
        chk("rst_f_gnt", f_gnt, 1'b0);
        chk("rst_l_gnt", l_gnt, 1'b0);
        chk("rst_m_en", m_en, 1'b0);
        chk("rst_m_we", m_we, 1'b0);
        adv();
        drive(1, 0, 0, '0, 0, 0, '0, '0, 32'h33);
        chk("rst_f_rvalid", f_rvalid, 1'b0);
        chk("rst_l_rvalid", l_rvalid, 1'b0);
        chk("rst_l_err", l_err, 1'b0);
        chk("rst_f_rdata", f_rdata, 32'h0);
        chk("rst_l_rdata", l_rdata, 32'h0);
        adv();

        for (int i = 0; i < 10; i++) begin
            drive(1, 0, 1, 32'h80, 1, 0, 32'h40, '0, $urandom);
            chk($sformatf("cont%0d_f", i), f_gnt, (i % 5) == 4);
            chk($sformatf("cont%0d_l", i), l_gnt, (i % 5) != 4);
            adv();
        end
        for (int i = 0; i < 10; i++) begin
            drive(1, 1, 1, 32'h80, 1, 0, 32'h40, '0, $urandom);
            chk($sformatf("boot%0d_f", i), f_gnt, 1'b0);
            chk($sformatf("boot%0d_l", i), l_gnt, 1'b1);
            adv();
        end
        for (int i = 0; i < 5; i++) begin
            drive(1, 0, 1, 32'h80, 1, 1, 32'h44, $urandom, $urandom);
            chk($sformatf("post%0d_f", i), f_gnt, (i % 5) == 4);
            adv();
        end

        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(29, 0) != 0, $urandom_range(7, 0) == 0, $urandom_range(1, 0) == 1,
                  $urandom, $urandom_range(1, 0) == 1, $urandom_range(1, 0) == 1,
                  ($urandom_range(3, 0) == 0) ? $urandom : ($urandom & 32'h1FFF),
                  $urandom, $urandom);
            adv();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/imem_arb.md
IMEM_ARB -- requirements
Module: imem_arb

Interface
REQ-001 SHALL have parameter MAX_STREAK, default 4, meaning the maximum number of consecutive loader grants while fetch waits.
REQ-002 SHALL have parameter AW, default 11, meaning the memory word-address width (2048 x 32-bit).
REQ-003 i_clk  in  1  clock; all state updates on rising edge.
REQ-004 i_rst  in  1  reset, synchronous, active-low.
REQ-005 i_boot  in  1  boot/load mode; 1 blocks fetch grants.
REQ-006 i_f_req  in  1  fetch read request.
REQ-007 i_f_addr  in  32  fetch byte address.
REQ-008 o_f_gnt  out  1  fetch request accepted this cycle.
REQ-009 o_f_rvalid  out  1  fetch read data valid.
REQ-010 o_f_rdata  out  32  fetch read data.
REQ-011 i_l_req  in  1  loader request.
REQ-012 i_l_we  in  1  loader write (1) / read (0).
REQ-013 i_l_addr  in  32  loader byte address.
REQ-014 i_l_wdata  in  32  loader write data.
REQ-015 o_l_gnt  out  1  loader request accepted this cycle.
REQ-016 o_l_rvalid  out  1  loader read data valid.
REQ-017 o_l_rdata  out  32  loader read data.
REQ-018 o_l_err  out  1  out-of-range loader access flag, pulse.
REQ-019 o_m_en, o_m_we  out  1 each  memory access enable / write enable.
REQ-020 o_m_addr  out  AW  memory word address.
REQ-021 o_m_wdata  out  32  memory write data.
REQ-022 i_m_rdata  in  32  memory read data, valid the cycle after a read access.

Function
REQ-023 Grants SHALL be combinational from requests and registered state; at most one of o_f_gnt/o_l_gnt high per cycle.
REQ-024 Word address SHALL be addr[AW+1:2]; addr[1:0] ignored.
REQ-025 A granted access SHALL drive o_m_en=1, o_m_addr and o_m_we=(loader & i_l_we) in the grant cycle; o_m_en=0 and o_m_we=0 otherwise.
REQ-026 Priority: loader wins, unless streak counter == MAX_STREAK and i_f_req=1 and i_boot=0, in which case fetch wins.
REQ-027 Streak counter SHALL increment on a loader grant while i_f_req=1 and i_boot=0, saturating at MAX_STREAK; clear on any fetch grant or when i_f_req=0.
REQ-028 i_boot=1: o_f_gnt=0 regardless of i_f_req; streak counter held at 0.
REQ-029 Loader access with addr[31:AW+2] non-zero SHALL be granted but suppressed (o_m_en=0); o_l_err=1 exactly one cycle later, o_l_rvalid stays 0.
REQ-030 Fetch addresses are not range-checked; upper bits are ignored.
REQ-031 Read latency: o_*_rvalid=1 exactly one cycle after the read grant, for one cycle, with o_*_rdata=i_m_rdata; a 1-bit owner tag register routes data.
REQ-032 Writes SHALL produce no rvalid.
REQ-033 Back-to-back grants every cycle SHALL be supported (full throughput, one access per cycle).
REQ-034 o_f_rdata/o_l_rdata SHALL hold the last delivered value while rvalid=0.

Reset
REQ-035 While i_rst=0 at a clock edge: streak=0, tag/rvalid registers=0, o_l_err=0, rdata registers=0.
REQ-036 During reset: o_f_gnt=0, o_l_gnt=0, o_m_en=0, o_m_we=0; requests are ignored.
REQ-037 A read granted in the cycle before reset assertion SHALL NOT produce rvalid after reset.

Verification
REQ-038 Fetch only: i_f_req=1, i_f_addr=0x10 -> o_f_gnt=1, o_m_addr=4; next cycle o_f_rvalid=1, o_f_rdata=i_m_rdata.
REQ-039 Loader write: i_l_we=1, addr=0x1FFC, wdata=0xDEADBEEF -> o_m_en=1, o_m_we=1, o_m_addr=0x7FF; no rvalid.
REQ-040 Contention: both requesting continuously, i_boot=0 -> grant pattern L,L,L,L,F repeating.
REQ-041 Boot: i_boot=1, both requesting 10 cycles -> 10 loader grants, o_f_gnt never 1.
REQ-042 Range: loader read addr=0x2000 -> o_m_en=0, next cycle o_l_err=1, o_l_rvalid=0.
REQ-043 Reset mid-read: fetch read granted, i_rst=0 next edge -> o_f_rvalid=0 and all outputs at reset values.
